// File: rtl/cmd_fetch.sv
// cmd_fetch: command-stream fetcher for the graphics front end.
// Walks a packed command buffer (header word + argument words) in the
// command BRAM. Headers are read through the one-word port and arguments
// through the four-word burst port. Header and argument beats are streamed
// downstream over a valid/ready interface.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  one-cycle pulse, begin fetch (ignored while busy)
//   base_addr, num_words   word address of first header, stream length
//   busy, done, err        status: running, end pulse, sticky overrun flag
//   mem_addr1 / mem_read0  header address / word at that address
//   mem_addr2 / mem_read1..4  burst base address / words at +0..+3
//   out_valid, out_ready   beat handshake
//   out_hdr, out_opcode    header-beat flag and header[7:0]
//   out_data, out_keep     up to four words and their valid-word mask
//   out_last               final beat of the current command
module cmd_fetch (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  base_addr,
  input  logic [31:0]  num_words,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  mem_addr1,
  input  logic [31:0]  mem_read0,
  output logic [31:0]  mem_addr2,
  input  logic [31:0]  mem_read1,
  input  logic [31:0]  mem_read2,
  input  logic [31:0]  mem_read3,
  input  logic [31:0]  mem_read4,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_hdr,
  output logic [7:0]   out_opcode,
  output logic [127:0] out_data,
  output logic [3:0]   out_keep,
  output logic         out_last
);

  typedef enum logic [1:0] {IDLE, HDR, ARGS, DONE} state_t;

  state_t        state, state_nx;
  logic [31:0]   ptr, ptr_nx, end_addr;
  logic [7:0]    rem, rem_nx, argc, rem_left;
  logic [2:0]    n;
  logic          ld, overrun, err_set;
  logic          beat_ld, beat_hdr, beat_last;
  logic [3:0]    beat_keep;
  logic [7:0]    beat_op;
  logic [127:0]  beat_data;

  // Both BRAM addresses are the registered pointer itself.
  assign mem_addr1 = ptr;
  assign mem_addr2 = ptr;

  assign ld       = !out_valid || out_ready;
  assign argc     = mem_read0[31] ? mem_read0[15:8] : '0;
  // 33-bit compare so ptr+1+argc cannot wrap past end_addr unnoticed.
  assign overrun  = ({1'b0, ptr} + 33'd1 + {25'b0, argc}) > {1'b0, end_addr};
  assign n        = (rem >= 8'd4) ? 3'd4 : rem[2:0];
  assign rem_left = rem - {5'b0, n};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and datapath decisions
  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    rem_nx    = rem;
    err_set   = 1'b0;
    beat_ld   = 1'b0;
    beat_hdr  = 1'b0;
    beat_last = 1'b0;
    beat_keep = '0;
    beat_op   = '0;
    beat_data = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ptr_nx   = base_addr;
          state_nx = (num_words == '0) ? DONE : HDR;
        end
      end
      HDR: begin
        if (ld) begin
          if (overrun) begin
            err_set  = 1'b1;
            state_nx = DONE;
          end else begin
            beat_ld   = 1'b1;
            beat_hdr  = 1'b1;
            beat_keep = 4'b0001;
            beat_last = (argc == '0);
            beat_op   = mem_read0[7:0];
            beat_data = {96'b0, mem_read0};
            ptr_nx    = ptr + 32'd1;
            rem_nx    = argc;
            if (argc != '0)            state_nx = ARGS;
            else if (ptr_nx == end_addr) state_nx = DONE;
            else                       state_nx = HDR;
          end
        end
      end
      ARGS: begin
        if (ld) begin
          beat_ld   = 1'b1;
          beat_keep = 4'((5'd1 << n) - 5'd1);
          beat_data = {mem_read4, mem_read3, mem_read2, mem_read1};
          ptr_nx    = ptr + {29'b0, n};
          rem_nx    = rem_left;
          if (rem_left == '0) begin
            beat_last = 1'b1;
            state_nx  = (ptr_nx == end_addr) ? DONE : HDR;
          end
        end
      end
      DONE: state_nx = IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    busy = (state == HDR) || (state == ARGS);
    done = (state == DONE);
  end

  // Pointer, bounds, error flag and output beat register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      end_addr   <= '0;
      rem        <= '0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      out_hdr    <= 1'b0;
      out_last   <= 1'b0;
      out_keep   <= '0;
      out_opcode <= '0;
      out_data   <= '0;
    end else begin
      ptr <= ptr_nx;
      rem <= rem_nx;
      if (state == IDLE && start) begin
        end_addr <= base_addr + num_words;
        err      <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
      out_valid <= beat_ld || (out_valid && !out_ready);
      if (beat_ld) begin
        out_hdr    <= beat_hdr;
        out_last   <= beat_last;
        out_keep   <= beat_keep;
        out_opcode <= beat_op;
        out_data   <= beat_data;
      end
    end
  end

endmodule
